// File: rtl/pad_arb_pkg.sv
// -----------------------------------------------------------------------------
// pad_arb_pkg
// Shared types and width helpers for the pad-sharing arbiter.
//   pad_arb_state_e : arbiter FSM states (IDLE, OWNED, TURN)
//   idx_w()         : width of a requester index for a given requester count
//   cnt_w()         : width of a counter that must hold values 0..max
// -----------------------------------------------------------------------------
package pad_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWNED = 2'd1,
        TURN  = 2'd2
    } pad_arb_state_e;

    // Requester index width; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width for a counter that has to reach 'max' inclusive.
    function automatic int cnt_w(input int max);
        return (max > 0) ? $clog2(max + 1) : 1;
    endfunction

endpackage

// File: rtl/pad_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// pad_arb_rr_pick
// Combinational round-robin picker. The search starts one past the last
// granted index and wraps modulo NUM_REQ; the first active request wins.
// Ports:
//   i_req        in  NUM_REQ  request vector
//   i_last_grant in  IDX_W    index granted most recently
//   o_winner     out IDX_W    selected requester (0 when no request)
//   o_any_req    out 1        at least one request is active
// -----------------------------------------------------------------------------
module pad_arb_rr_pick
    import pad_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [IDX_W-1:0]   o_winner,
    output logic               o_any_req
);

    // One extra bit: last_grant + offset can reach 2*NUM_REQ-1 before wrapping.
    logic [IDX_W:0] w_cand;
    logic           w_found;

    always_comb begin
        o_winner = '0;
        w_found  = 1'b0;
        w_cand   = '0;
        // Offsets 1..NUM_REQ: the last winner is visited last, so it only
        // wins again when nobody else is asking.
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_cand = {1'b0, i_last_grant} + (IDX_W + 1)'(i);
            if (w_cand >= (IDX_W + 1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(NUM_REQ);
            end
            if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
                o_winner = w_cand[IDX_W-1:0];
                w_found  = 1'b1;
            end
        end
    end

    assign o_any_req = |i_req;

endmodule

// File: rtl/pad_share_arbiter.sv
// -----------------------------------------------------------------------------
// pad_share_arbiter
// Time-multiplexes one group of pads between NUM_REQ peripherals using a
// req/gnt handshake, round-robin ownership and a tristated turnaround gap of
// TURNAROUND+1 cycles between owners so two drivers never overlap.
// Optional build macro: PAD_ARB_PREEMPT_EN -- adds a hold counter that takes
// the pads away from an owner after HOLD_LIMIT cycles when someone else waits.
// Ports:
//   clk_i     in  1                  clock
//   rst_ni    in  1                  asynchronous active-low reset
//   req_i     in  NUM_REQ            requests (level, held while wanted)
//   gnt_o     out NUM_REQ            grant, one-hot or zero
//   out_i     in  NUM_REQ x NUM_PADS per-requester pad output data
//   oe_i      in  NUM_REQ x NUM_PADS per-requester pad output enables
//   in_o      out NUM_REQ x NUM_PADS pad input values returned per requester
//   pad_out_o out NUM_PADS           data to IO buffers
//   pad_oe_o  out NUM_PADS           enables to IO buffers (1 = drive)
//   pad_in_i  in  NUM_PADS           data from IO buffers
//   busy_o    out 1                  FSM not in IDLE
//   owner_o   out $clog2(NUM_REQ)    current owner index
// -----------------------------------------------------------------------------
module pad_share_arbiter
    import pad_arb_pkg::*;
#(
    parameter int                  NUM_REQ    = 2,
    parameter int                  NUM_PADS   = 2,
    parameter int                  TURNAROUND = 2,
    parameter int                  HOLD_LIMIT = 1024,
    parameter logic [NUM_PADS-1:0] IDLE_IN    = '1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_i,
    output logic [NUM_REQ-1:0]                 gnt_o,
    input  logic [NUM_REQ-1:0][NUM_PADS-1:0]   out_i,
    input  logic [NUM_REQ-1:0][NUM_PADS-1:0]   oe_i,
    output logic [NUM_REQ-1:0][NUM_PADS-1:0]   in_o,
    output logic [NUM_PADS-1:0]                pad_out_o,
    output logic [NUM_PADS-1:0]                pad_oe_o,
    input  logic [NUM_PADS-1:0]                pad_in_i,
    output logic                               busy_o,
    output logic [idx_w(NUM_REQ)-1:0]          owner_o
);

    localparam int OWN_W  = idx_w(NUM_REQ);
    localparam int TURN_W = cnt_w(TURNAROUND);
    localparam logic [NUM_REQ-1:0] GNT_ONE = NUM_REQ'(1);

    pad_arb_state_e      r_state;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [OWN_W-1:0]    r_owner;
    logic [OWN_W-1:0]    r_last_grant;
    logic [TURN_W-1:0]   r_turn_cnt;
    logic                r_busy;

    logic [OWN_W-1:0]    w_winner;
    logic                w_any_req;
    logic                w_release;
    logic                w_preempt;

    // Single picker shared by the IDLE and end-of-TURN decisions.
    pad_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr_pick (
        .i_req        (req_i),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_any_req    (w_any_req)
    );

    assign w_release = !req_i[r_owner];

`ifdef PAD_ARB_PREEMPT_EN
    localparam int HOLD_W = cnt_w(HOLD_LIMIT);

    logic [HOLD_W-1:0] r_hold_cnt;
    logic              w_hold_expired;
    logic              w_other_req;

    // Counter sits at zero outside OWNED, so every entry to OWNED starts
    // from zero; it saturates so a lone owner keeps the expired flag set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_hold_cnt <= '0;
        end else if (r_state != OWNED) begin
            r_hold_cnt <= '0;
        end else if (r_hold_cnt != HOLD_W'(HOLD_LIMIT)) begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
    end

    // The edge being decided is the HOLD_LIMIT-th owned edge when the
    // counter already shows HOLD_LIMIT-1.
    assign w_hold_expired = (r_hold_cnt >= HOLD_W'(HOLD_LIMIT - 1));
    assign w_other_req    = |(req_i & ~r_gnt);
    assign w_preempt      = w_hold_expired && w_other_req;
`else
    assign w_preempt = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_gnt        <= '0;
            r_owner      <= '0;
            r_last_grant <= OWN_W'(NUM_REQ - 1);
            r_turn_cnt   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_state      <= OWNED;
                        r_gnt        <= GNT_ONE << w_winner;
                        r_owner      <= w_winner;
                        r_last_grant <= w_winner;
                        r_busy       <= 1'b1;
                    end
                end
                OWNED: begin
                    // Release and preemption share one exit path and timing.
                    if (w_release || w_preempt) begin
                        r_state    <= TURN;
                        r_gnt      <= '0;
                        r_turn_cnt <= '0;
                    end
                end
                TURN: begin
                    // TURN spans TURNAROUND+1 cycles including the release
                    // cycle's edge, giving the exact oe-low gap between owners.
                    if (r_turn_cnt == TURN_W'(TURNAROUND)) begin
                        r_turn_cnt <= '0;
                        if (w_any_req) begin
                            r_state      <= OWNED;
                            r_gnt        <= GNT_ONE << w_winner;
                            r_owner      <= w_winner;
                            r_last_grant <= w_winner;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_turn_cnt <= r_turn_cnt + TURN_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Pad mux follows the registered owner; outside OWNED the pads are
    // released so reset and turnaround force all enables low.
    always_comb begin
        pad_out_o = '0;
        pad_oe_o  = '0;
        if (r_state == OWNED) begin
            pad_out_o = out_i[r_owner];
            pad_oe_o  = oe_i[r_owner];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_in_ret
            assign in_o[gi] = r_gnt[gi] ? pad_in_i : IDLE_IN;
        end
    endgenerate

    assign gnt_o   = r_gnt;
    assign owner_o = r_owner;
    assign busy_o  = r_busy;

endmodule
